lsu_ctrl: RTL and testbench
===========================

// Module: lsu_ctrl
// PURPOSE
//  Load/store sequencer between the core's memory stage and the byte-addressed data_memory.
//  Accepts one load/store per handshake, decodes RV64 funct3 size/sign, builds byte strobes,
//  and splits accesses that cross an 8-byte boundary into two aligned doubleword accesses.
//  Returns aligned, sign/zero-extended load data; flags illegal or out-of-range requests.
// PARAMETERS
//  XLEN       64    data/address width
//  MEM_BYTES  1024  data memory size in bytes; any access touching byte >= MEM_BYTES faults
// PORTS
//  clk         in   1     clock, rising edge
//  rstn        in   1     asynchronous reset, active low
//  req_valid   in   1     request present
//  req_ready   out  1     high only in IDLE
//  req_write   in   1     1=store, 0=load
//  req_funct3  in   3     000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu
//  req_addr    in   XLEN  byte address, any alignment
//  req_wdata   in   XLEN  store data, LSBs used
//  resp_valid  out  1     response held until resp_ready
//  resp_ready  in   1     consumer accepts response
//  resp_rdata  out  XLEN  extended load data; 0 for stores and faults
//  resp_fault  out  1     illegal funct3 or range violation
//  mem_addr    out  XLEN  doubleword-aligned address (low 3 bits 0)
//  mem_wdata   out  64    lane-positioned store data
//  mem_wstrb   out  8     byte-lane write enables
//  mem_write_en out 1     write strobe, committed at clk edge
//  mem_read_en  out 1     read strobe; mem_rdata is combinational, same cycle
//  mem_rdata   in   64    read data from data_memory
// BEHAVIOUR
//  Reset (async, rstn=0): state IDLE; all outputs 0 except req_ready=1; buffers cleared.
//  FSM: IDLE -> ACC0 -> [ACC1] -> RESP -> IDLE.
//   IDLE: req_valid&&req_ready captures addr/funct3/wdata/write; next ACC0, or RESP with fault.
//   ACC0: access aligned dword addr&~7; read_en or write_en = 1; next ACC1 if split, else RESP.
//   ACC1: access addr&~7 + 8; next RESP.
//   RESP: resp_valid=1; rdata/fault stable; on resp_ready -> IDLE; req_ready rises next cycle.
//  Latency, accept edge to resp_valid: 2 cycles unsplit, 3 split, 1 for faults.
//  Width rules: size = 1<<funct3[1:0]; off = addr[2:0]; split iff off+size > 8.
//   mask16 = ((1<<size)-1)<<off; wstrb = mask16[7:0] in ACC0, mask16[15:8] in ACC1.
//   wdata128 = wdata<<(8*off); mem_wdata = low half in ACC0, high half in ACC1.
//   Load: mem_rdata latched into buf128 low (ACC0) / high (ACC1) half.
//   result = buf128>>(8*off), truncated to size, then extended: funct3[2]=0 sign-extends,
//   funct3[2]=1 zero-extends; ld always full width.
//  Faults, with no mem strobe asserted: funct3=111; store with funct3[2]=1;
//   addr+size > MEM_BYTES (XLEN+1-bit sum, no wrap).
//  Strobes are never asserted outside ACC0/ACC1. The last dword is not wrapped to address 0.
//  Reset mid-op: abort immediately; a committed ACC0 half-store is not rolled back; no response.
// STRUCTURE
//  lsu_pkg: funct3 codes, SZ_* constants, state encoding (IDLE/ACC0/ACC1/RESP).
//  Sub-module lsu_align (combinational): strobe/mask gen, store shift, load shift + extend.
//  lsu_ctrl keeps FSM, capture regs, buf128 and the handshakes.
// TESTING
//  1. sd 0x10 <- 0x1122334455667788, then ld 0x10 -> rdata 0x1122334455667788;
//     one write cycle with wstrb 0xFF; resp 2 cycles after accept.
//  2. Byte 0x80 at 0x13: lb -> 0xFFFFFFFFFFFFFF80; lbu -> 0x0000000000000080;
//     single read at mem_addr 0x10.
//  3. sw 0x0E <- 0xAABBCCDD -> ACC0 addr 0x08 wstrb 0xC0, ACC1 addr 0x10 wstrb 0x03;
//     lw 0x0E -> 0xFFFFFFFFAABBCCDD; lwu -> 0x00000000AABBCCDD.
//  4. funct3=111, sb funct3=100, and ld 0x3FC -> resp_fault=1, rdata 0,
//     no mem strobes, resp 1 cycle after accept.
//  5. resp_ready held low 3 cycles -> resp_valid/rdata stable, req_ready=0;
//     back-to-back requests accepted one cycle after each response handshake.
//  6. rstn pulsed low during ACC1 of a split sd -> outputs 0 asynchronously, state IDLE;
//     next ld completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer: funct3 codes, access sizes,
// FSM state encoding and the funct3-to-size decode.
package lsu_pkg;

  localparam int XLEN_DEF      = 64;
  localparam int MEM_BYTES_DEF = 1024;

  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_ILL = 3'b111;

  localparam logic [3:0] SZ_B = 4'd1;
  localparam logic [3:0] SZ_H = 4'd2;
  localparam logic [3:0] SZ_W = 4'd4;
  localparam logic [3:0] SZ_D = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  function automatic logic [3:0] f3_size(input logic [1:0] f3_lo);
    case (f3_lo)
      2'b00:   f3_size = SZ_B;
      2'b01:   f3_size = SZ_H;
      2'b10:   f3_size = SZ_W;
      default: f3_size = SZ_D;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte strobes, store data positioning across two
// doublewords, legality/range check and load extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic [XLEN-1:0] i_addr,
  input  logic [2:0]      i_funct3,
  input  logic            i_write,
  input  logic [XLEN-1:0] i_wdata,
  input  logic            i_hi,
  input  logic [127:0]    i_buf,
  output logic            o_split,
  output logic            o_fault,
  output logic [7:0]      o_wstrb,
  output logic [63:0]     o_wdata,
  output logic [XLEN-1:0] o_rdata
);

  localparam logic [XLEN:0] MEM_LIMIT = (XLEN+1)'(MEM_BYTES);

  logic [3:0]   w_size;
  logic [2:0]   w_off;
  logic [15:0]  w_mask16;
  logic [127:0] w_wdata128;
  logic [XLEN:0] w_end;
  logic [63:0]  w_shift;

  assign w_size     = f3_size(i_funct3[1:0]);
  assign w_off      = i_addr[2:0];
  assign o_split    = ({1'b0, w_off} + w_size) > 4'd8;
  assign w_mask16   = ((16'd1 << w_size) - 16'd1) << w_off;
  assign w_wdata128 = 128'(i_wdata) << {w_off, 3'b000};
  assign o_wstrb    = i_hi ? w_mask16[15:8] : w_mask16[7:0];
  assign o_wdata    = i_hi ? w_wdata128[127:64] : w_wdata128[63:0];

  // The end-of-access sum is one bit wider so an address near the top cannot wrap into range.
  assign w_end   = {1'b0, i_addr} + (XLEN+1)'(w_size);
  assign o_fault = (i_funct3 == F3_ILL) || (i_write && i_funct3[2]) || (w_end > MEM_LIMIT);
  assign w_shift = 64'(i_buf >> {w_off, 3'b000});

  // Truncate the shifted buffer to the access size and extend to XLEN.
  always_comb begin
    case (i_funct3)
      F3_B:    o_rdata = {{(XLEN-8){w_shift[7]}}, w_shift[7:0]};
      F3_H:    o_rdata = {{(XLEN-16){w_shift[15]}}, w_shift[15:0]};
      F3_W:    o_rdata = {{(XLEN-32){w_shift[31]}}, w_shift[31:0]};
      F3_BU:   o_rdata = {{(XLEN-8){1'b0}}, w_shift[7:0]};
      F3_HU:   o_rdata = {{(XLEN-16){1'b0}}, w_shift[15:0]};
      F3_WU:   o_rdata = {{(XLEN-32){1'b0}}, w_shift[31:0]};
      F3_D:    o_rdata = XLEN'(w_shift);
      default: o_rdata = XLEN'(w_shift);
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: request capture, IDLE/ACC0/ACC1/RESP sequencing of one or
// two aligned doubleword accesses, load buffer and response handshake. All outputs registered.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_fault,
  output logic [XLEN-1:0] mem_addr,
  output logic [63:0]     mem_wdata,
  output logic [7:0]      mem_wstrb,
  output logic            mem_write_en,
  output logic            mem_read_en,
  input  logic [63:0]     mem_rdata
);

  lsu_state_e      r_state;
  logic [XLEN-1:0] r_addr;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_wdata;
  logic            r_write;
  logic [127:0]    r_buf;
  logic            r_req_ready;
  logic            r_resp_valid;
  logic [XLEN-1:0] r_resp_rdata;
  logic            r_resp_fault;
  logic [XLEN-1:0] r_mem_addr;
  logic [63:0]     r_mem_wdata;
  logic [7:0]      r_mem_wstrb;
  logic            r_mem_write_en;
  logic            r_mem_read_en;

  logic            w_idle;
  logic [XLEN-1:0] w_addr;
  logic [2:0]      w_funct3;
  logic [XLEN-1:0] w_wdata;
  logic            w_write;
  logic [127:0]    w_buf_next;
  logic            w_split;
  logic            w_fault;
  logic [7:0]      w_wstrb;
  logic [63:0]     w_mem_wdata;
  logic [XLEN-1:0] w_rdata;

  // In IDLE the lane logic looks at the live request so ACC0 strobes can be registered on accept.
  assign w_idle     = (r_state == ST_IDLE);
  assign w_addr     = w_idle ? req_addr   : r_addr;
  assign w_funct3   = w_idle ? req_funct3 : r_funct3;
  assign w_wdata    = w_idle ? req_wdata  : r_wdata;
  assign w_write    = w_idle ? req_write  : r_write;
  assign w_buf_next = (r_state == ST_ACC1) ? {mem_rdata, r_buf[63:0]} : {r_buf[127:64], mem_rdata};

  lsu_align #(.XLEN(XLEN), .MEM_BYTES(MEM_BYTES)) u_align (
    .i_addr   (w_addr),
    .i_funct3 (w_funct3),
    .i_write  (w_write),
    .i_wdata  (w_wdata),
    .i_hi     (r_state == ST_ACC0),
    .i_buf    (w_buf_next),
    .o_split  (w_split),
    .o_fault  (w_fault),
    .o_wstrb  (w_wstrb),
    .o_wdata  (w_mem_wdata),
    .o_rdata  (w_rdata)
  );

  // Sequencer FSM with capture registers, load buffer and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state        <= ST_IDLE;
      r_addr         <= {XLEN{1'b0}};
      r_funct3       <= 3'd0;
      r_wdata        <= {XLEN{1'b0}};
      r_write        <= 1'b0;
      r_buf          <= 128'd0;
      r_req_ready    <= 1'b1;
      r_resp_valid   <= 1'b0;
      r_resp_rdata   <= {XLEN{1'b0}};
      r_resp_fault   <= 1'b0;
      r_mem_addr     <= {XLEN{1'b0}};
      r_mem_wdata    <= 64'd0;
      r_mem_wstrb    <= 8'd0;
      r_mem_write_en <= 1'b0;
      r_mem_read_en  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_addr      <= req_addr;
            r_funct3    <= req_funct3;
            r_wdata     <= req_wdata;
            r_write     <= req_write;
            r_req_ready <= 1'b0;
            if (w_fault) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_rdata <= {XLEN{1'b0}};
              r_resp_fault <= 1'b1;
            end else begin
              r_state        <= ST_ACC0;
              r_mem_addr     <= {req_addr[XLEN-1:3], 3'b000};
              r_mem_wdata    <= req_write ? w_mem_wdata : 64'd0;
              r_mem_wstrb    <= req_write ? w_wstrb : 8'd0;
              r_mem_write_en <= req_write;
              r_mem_read_en  <= ~req_write;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ACC0: begin
          r_buf <= w_buf_next;
          if (w_split) begin
            r_state     <= ST_ACC1;
            r_mem_addr  <= {r_addr[XLEN-1:3], 3'b000} + XLEN'(8);
            r_mem_wdata <= r_write ? w_mem_wdata : 64'd0;
            r_mem_wstrb <= r_write ? w_wstrb : 8'd0;
          end else begin
            r_state        <= ST_RESP;
            r_mem_addr     <= {XLEN{1'b0}};
            r_mem_wdata    <= 64'd0;
            r_mem_wstrb    <= 8'd0;
            r_mem_write_en <= 1'b0;
            r_mem_read_en  <= 1'b0;
            r_resp_valid   <= 1'b1;
            r_resp_rdata   <= r_write ? {XLEN{1'b0}} : w_rdata;
            r_resp_fault   <= 1'b0;
          end
        end
        ST_ACC1: begin
          r_buf          <= w_buf_next;
          r_state        <= ST_RESP;
          r_mem_addr     <= {XLEN{1'b0}};
          r_mem_wdata    <= 64'd0;
          r_mem_wstrb    <= 8'd0;
          r_mem_write_en <= 1'b0;
          r_mem_read_en  <= 1'b0;
          r_resp_valid   <= 1'b1;
          r_resp_rdata   <= r_write ? {XLEN{1'b0}} : w_rdata;
          r_resp_fault   <= 1'b0;
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_state      <= ST_IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= {XLEN{1'b0}};
            r_resp_fault <= 1'b0;
          end else begin
            r_state <= ST_RESP;
          end
        end
        default: begin
          r_state        <= ST_IDLE;
          r_req_ready    <= 1'b1;
          r_resp_valid   <= 1'b0;
          r_mem_write_en <= 1'b0;
          r_mem_read_en  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready    = r_req_ready;
  assign resp_valid   = r_resp_valid;
  assign resp_rdata   = r_resp_rdata;
  assign resp_fault   = r_resp_fault;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign mem_wstrb    = r_mem_wstrb;
  assign mem_write_en = r_mem_write_en;
  assign mem_read_en  = r_mem_read_en;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: byte-array data memory, byte-level reference model of the
// load/store rules, directed scenarios plus a randomized run.
module tb_lsu_ctrl;

  localparam int MEMB = 1024;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [63:0] req_addr = 64'd0, req_wdata = 64'd0;
  logic        resp_valid, resp_ready = 1'b0, resp_fault;
  logic [63:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wstrb;
  logic        mem_write_en, mem_read_en;

  logic [7:0]  dmem [MEMB];
  logic [7:0]  ref_mem [MEMB];
  logic        mem_init = 1'b1;
  int          n_checks = 0, n_fail = 0;
  int          n_rd = 0, n_wr = 0;
  logic [63:0] wr_addr_q[$], rd_addr_q[$];
  logic [7:0]  wr_strb_q[$];

  always #5 clk = ~clk;

  lsu_ctrl #(.XLEN(64), .MEM_BYTES(MEMB)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
    .mem_rdata(mem_rdata)
  );

  // Data memory: writes commit at the clock edge, reads are combinational.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < MEMB; i++) dmem[i] <= 8'(i * 37 + 11);
    end else if (mem_write_en) begin
      for (int i = 0; i < 8; i++)
        if (mem_wstrb[i] && (mem_addr + 64'(i) < 64'(MEMB))) dmem[32'(mem_addr) + i] <= mem_wdata[8*i +: 8];
    end
  end

  always_comb begin
    mem_rdata = 64'd0;
    for (int i = 0; i < 8; i++)
      if (mem_addr + 64'(i) < 64'(MEMB)) mem_rdata[8*i +: 8] = dmem[32'(mem_addr) + i];
  end

  // Strobe monitor.
  always @(posedge clk) begin
    if (mem_write_en) begin n_wr++; wr_addr_q.push_back(mem_addr); wr_strb_q.push_back(mem_wstrb); end
    if (mem_read_en) begin n_rd++; rd_addr_q.push_back(mem_addr); end
  end

  function automatic int sz(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic exp_fault(input logic w, input logic [2:0] f3, input logic [63:0] a);
    logic [64:0] e;
    e = {1'b0, a} + 65'(sz(f3));
    return (f3 == 3'd7) || (w && f3[2]) || (e > 65'(MEMB));
  endfunction

  function automatic logic is_split(input logic [2:0] f3, input logic [63:0] a);
    return (int'(a[2:0]) + sz(f3)) > 8;
  endfunction

  function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [63:0] a);
    logic [63:0] v;
    int n;
    v = 64'd0;
    n = sz(f3);
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[32'(a) + i];
    if (!f3[2] && n < 8 && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
    for (int i = 0; i < sz(f3); i++) ref_mem[32'(a) + i] = wd[8*i +: 8];
  endtask

  // Present one request at the next edge and wait (bounded) for the response.
  task automatic issue(input logic w, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, output int lat);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    if (!resp_valid) begin
      n_checks++; n_fail++;
      $display("FAIL timeout: resp_valid never rose for addr %h funct3 %0d", a, f3);
    end
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({req_ready, resp_valid, resp_fault, mem_read_en, mem_write_en} !== 5'b10000) begin
      n_fail++; $display("FAIL reset_ctl: got %b want 10000", {req_ready, resp_valid, resp_fault, mem_read_en, mem_write_en});
    end
    n_checks++;
    if ({resp_rdata, mem_addr, mem_wdata, mem_wstrb} !== 200'd0) begin
      n_fail++; $display("FAIL reset_data: rdata %h addr %h wdata %h wstrb %h", resp_rdata, mem_addr, mem_wdata, mem_wstrb);
    end
  endtask

  task automatic test_sd_ld();
    int lat, w0, q0;
    w0 = n_wr; q0 = wr_strb_q.size();
    issue(1'b1, 3'd3, 64'h10, 64'h1122334455667788, lat);
    n_checks++;
    if (lat != 2 || resp_fault !== 1'b0 || resp_rdata !== 64'd0) begin
      n_fail++; $display("FAIL sd_resp: lat %0d fault %b rdata %h want 2 0 0", lat, resp_fault, resp_rdata);
    end
    ack();
    model_store(3'd3, 64'h10, 64'h1122334455667788);
    n_checks++;
    if (n_wr - w0 != 1 || wr_strb_q[q0] !== 8'hFF || wr_addr_q[q0] !== 64'h10) begin
      n_fail++; $display("FAIL sd_strobe: writes %0d strb %h addr %h want 1 ff 10", n_wr - w0, wr_strb_q[q0], wr_addr_q[q0]);
    end
    issue(1'b0, 3'd3, 64'h10, 64'd0, lat);
    n_checks++;
    if (lat != 2 || resp_rdata !== 64'h1122334455667788) begin
      n_fail++; $display("FAIL ld_data: lat %0d rdata %h want 2 1122334455667788", lat, resp_rdata);
    end
    ack();
  endtask

  task automatic test_byte_ext();
    int lat, r0, q0;
    issue(1'b1, 3'd0, 64'h13, 64'h80, lat);
    ack();
    model_store(3'd0, 64'h13, 64'h80);
    r0 = n_rd; q0 = rd_addr_q.size();
    issue(1'b0, 3'd0, 64'h13, 64'd0, lat);
    n_checks++;
    if (resp_rdata !== 64'hFFFFFFFFFFFFFF80) begin
      n_fail++; $display("FAIL lb: got %h want ffffffffffffff80", resp_rdata);
    end
    ack();
    n_checks++;
    if (n_rd - r0 != 1 || rd_addr_q[q0] !== 64'h10) begin
      n_fail++; $display("FAIL lb_read: reads %0d addr %h want 1 10", n_rd - r0, rd_addr_q[q0]);
    end
    issue(1'b0, 3'd4, 64'h13, 64'd0, lat);
    n_checks++;
    if (resp_rdata !== 64'h80) begin
      n_fail++; $display("FAIL lbu: got %h want 80", resp_rdata);
    end
    ack();
  endtask

  task automatic test_split_word();
    int lat, w0, q0;
    w0 = n_wr; q0 = wr_strb_q.size();
    issue(1'b1, 3'd2, 64'h0E, 64'hAABBCCDD, lat);
    ack();
    model_store(3'd2, 64'h0E, 64'hAABBCCDD);
    n_checks++;
    if (lat != 3 || n_wr - w0 != 2 || wr_addr_q[q0] !== 64'h08 || wr_strb_q[q0] !== 8'hC0 ||
        wr_addr_q[q0+1] !== 64'h10 || wr_strb_q[q0+1] !== 8'h03) begin
      n_fail++;
      $display("FAIL sw_split: lat %0d writes %0d a0 %h s0 %h a1 %h s1 %h want 3 2 08 c0 10 03",
               lat, n_wr - w0, wr_addr_q[q0], wr_strb_q[q0], wr_addr_q[q0+1], wr_strb_q[q0+1]);
    end
    issue(1'b0, 3'd2, 64'h0E, 64'd0, lat);
    n_checks++;
    if (lat != 3 || resp_rdata !== 64'hFFFFFFFFAABBCCDD) begin
      n_fail++; $display("FAIL lw_split: lat %0d got %h want 3 ffffffffaabbccdd", lat, resp_rdata);
    end
    ack();
    issue(1'b0, 3'd6, 64'h0E, 64'd0, lat);
    n_checks++;
    if (resp_rdata !== 64'h00000000AABBCCDD) begin
      n_fail++; $display("FAIL lwu_split: got %h want 00000000aabbccdd", resp_rdata);
    end
    ack();
  endtask

  task automatic test_faults();
    logic        fw [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  ff3 [3] = '{3'd7, 3'd4, 3'd3};
    logic [63:0] fa [3] = '{64'h20, 64'h20, 64'h3FC};
    int lat, r0, w0;
    for (int k = 0; k < 3; k++) begin
      r0 = n_rd; w0 = n_wr;
      issue(fw[k], ff3[k], fa[k], 64'hDEADBEEFCAFEF00D, lat);
      n_checks++;
      if (resp_fault !== 1'b1 || resp_rdata !== 64'd0 || lat != 1 || n_rd != r0 || n_wr != w0) begin
        n_fail++; $display("FAIL fault_%0d: fault %b rdata %h lat %0d rd %0d wr %0d want 1 0 1 0 0",
                           k, resp_fault, resp_rdata, lat, n_rd - r0, n_wr - w0);
      end
      ack();
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [63:0] held;
    issue(1'b0, 3'd3, 64'h10, 64'd0, lat);
    held = model_load(3'd3, 64'h10);
    for (int c = 0; c < 3; c++) begin
      req_valid = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== held || req_ready !== 1'b0) begin
        n_fail++; $display("FAIL stall_%0d: valid %b rdata %h ready %b want 1 %h 0", c, resp_valid, resp_rdata, req_ready, held);
      end
    end
    req_valid = 1'b0;
    ack();
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_ack: got %b want 1", req_ready);
    end
    issue(1'b0, 3'd2, 64'h0E, 64'd0, lat);
    n_checks++;
    if (lat != 3 || resp_rdata !== model_load(3'd2, 64'h0E)) begin
      n_fail++; $display("FAIL b2b_lw: lat %0d got %h want 3 %h", lat, resp_rdata, model_load(3'd2, 64'h0E));
    end
    ack();
    issue(1'b0, 3'd0, 64'h13, 64'd0, lat);
    n_checks++;
    if (lat != 2 || resp_rdata !== model_load(3'd0, 64'h13)) begin
      n_fail++; $display("FAIL b2b_lb: lat %0d got %h want 2 %h", lat, resp_rdata, model_load(3'd0, 64'h13));
    end
    ack();
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [63:0] wd = 64'h0102030405060708;
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd3; req_addr = 64'h0C; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (mem_write_en !== 1'b1 || mem_addr !== 64'h10) begin
      n_fail++; $display("FAIL mid_acc1: wen %b addr %h want 1 10", mem_write_en, mem_addr);
    end
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, resp_valid, mem_write_en, mem_read_en, mem_wstrb, mem_addr} !== {4'b1000, 72'd0}) begin
      n_fail++; $display("FAIL mid_reset: ready %b valid %b wen %b ren %b strb %h addr %h",
                         req_ready, resp_valid, mem_write_en, mem_read_en, mem_wstrb, mem_addr);
    end
    for (int i = 0; i < 4; i++) ref_mem[12 + i] = wd[8*i +: 8];
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_noresp: valid %b ready %b want 0 1", resp_valid, req_ready);
    end
    issue(1'b0, 3'd3, 64'h08, 64'd0, lat);
    n_checks++;
    if (lat != 2 || resp_rdata !== model_load(3'd3, 64'h08)) begin
      n_fail++; $display("FAIL mid_ld: lat %0d got %h want 2 %h", lat, resp_rdata, model_load(3'd3, 64'h08));
    end
    ack();
  endtask

  task automatic test_random();
    int lat, r0, w0, elat, erd, ewr;
    logic w, ef;
    logic [2:0] f3;
    logic [63:0] a, wd, er;
    for (int k = 0; k < 60; k++) begin
      int sel;
      w = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      if (sel < 7) a = 64'($urandom_range(0, MEMB - 1));
      else if (sel < 9) a = 64'(MEMB - 16 + $urandom_range(0, 15));
      else a = {32'd0, $urandom};
      wd = {$urandom, $urandom};
      ef = exp_fault(w, f3, a);
      er = (ef || w) ? 64'd0 : model_load(f3, a);
      elat = ef ? 1 : (is_split(f3, a) ? 3 : 2);
      erd = (ef || w) ? 0 : (is_split(f3, a) ? 2 : 1);
      ewr = (ef || !w) ? 0 : (is_split(f3, a) ? 2 : 1);
      r0 = n_rd; w0 = n_wr;
      issue(w, f3, a, wd, lat);
      n_checks++;
      if (resp_fault !== ef || resp_rdata !== er || lat != elat) begin
        n_fail++; $display("FAIL rnd_%0d resp: w %b f3 %0d a %h fault %b/%b rdata %h/%h lat %0d/%0d",
                           k, w, f3, a, resp_fault, ef, resp_rdata, er, lat, elat);
      end
      n_checks++;
      if (n_rd - r0 != erd || n_wr - w0 != ewr) begin
        n_fail++; $display("FAIL rnd_%0d strobes: reads %0d/%0d writes %0d/%0d", k, n_rd - r0, erd, n_wr - w0, ewr);
      end
      ack();
      if (w && !ef) model_store(f3, a, wd);
    end
  endtask

  initial begin
    for (int i = 0; i < MEMB; i++) ref_mem[i] = 8'(i * 37 + 11);
    repeat (2) @(posedge clk);
    #1 mem_init = 1'b0;
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_sd_ld();
    test_byte_ext();
    test_split_word();
    test_faults();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
